karaoke_line_sequencer: RTL

Sequencer that drives the two sublist-line ROM buffers (sl0/sl1) of the karaoke display. It emits one column strobe per clock, carrying a character index and a column-within-character index. It ping-pongs the active buffer at each line boundary and requests the next lyric line into the idle buffer over a req/ack handshake. It sits between the top-level song control and the two `sublistROM` instances; it replaces the free-running testbench clock-gating loop as the source of line timing.

---
 rtl/karaoke_line_sequencer_pkg.sv | 29 ++
 rtl/karaoke_line_sequencer_col_counter.sv | 47 ++++
 rtl/karaoke_line_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/karaoke_line_sequencer_pkg.sv
// Shared state encoding, default geometry and width helper for the karaoke line sequencer.
// CPSBLN / CHAR_W may be pre-defined as macros to override the default line geometry.
`ifndef CPSBLN
`define CPSBLN 16
`endif
`ifndef CHAR_W
`define CHAR_W 8
`endif

package karaoke_line_sequencer_pkg;

  localparam int DEF_CPSBLN = `CPSBLN;
  localparam int DEF_CHAR_W = `CHAR_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRELOAD0  = 3'd1,
    ST_PRELOAD1  = 3'd2,
    ST_PLAY      = 3'd3,
    ST_WAIT_LOAD = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/karaoke_line_sequencer_col_counter.sv
// Character/column position counter for one sublist line, with enable,
// synchronous clear and a flag marking the final column of the line.
module karaoke_col_counter
  import karaoke_line_sequencer_pkg::*;
#(
  parameter int CPSBLN = DEF_CPSBLN,
  parameter int CHAR_W = DEF_CHAR_W,
  localparam int CI_W = idx_w(CPSBLN),
  localparam int CO_W = idx_w(CHAR_W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_en,
  output logic [CI_W-1:0] o_char_idx,
  output logic [CO_W-1:0] o_col_idx,
  output logic            o_last
);

  logic [CI_W-1:0] r_char;
  logic [CO_W-1:0] r_col;
  logic            w_col_end;
  logic            w_char_end;

  assign w_col_end  = (r_col == CO_W'(CHAR_W - 1));
  assign w_char_end = (r_char == CI_W'(CPSBLN - 1));
  assign o_last     = w_col_end && w_char_end;

  // Wrapping on the last column leaves the indices at zero for the next line.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_char <= '0;
      r_col  <= '0;
    end else if (i_en) begin
      if (w_col_end) begin
        r_col  <= '0;
        r_char <= w_char_end ? '0 : r_char + CI_W'(1);
      end else begin
        r_col <= r_col + CO_W'(1);
      end
    end
  end

  assign o_char_idx = r_char;
  assign o_col_idx  = r_col;

endmodule

// File: rtl/karaoke_line_sequencer.sv
// Ping-pong line sequencer for the two sublist buffers: column timing plus next-line
// load handshake. Define KARAOKE_LOOP_EN to wrap the song instead of stopping in DONE.
module karaoke_line_sequencer
  import karaoke_line_sequencer_pkg::*;
#(
  parameter int CPSBLN    = DEF_CPSBLN,
  parameter int CHAR_W    = DEF_CHAR_W,
  parameter int NUM_LINES = 36,
  parameter int LINE_AW   = 8,
  localparam int CI_W = idx_w(CPSBLN),
  localparam int CO_W = idx_w(CHAR_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  output logic               load_req,
  output logic               load_buf,
  output logic [LINE_AW-1:0] load_line,
  input  logic               load_ack,
  output logic               col_valid,
  output logic [CI_W-1:0]    char_idx,
  output logic [CO_W-1:0]    col_idx,
  output logic               active_sl,
  output logic [LINE_AW-1:0] cur_line,
  output logic               line_done,
  output logic               song_done
);

  localparam logic [LINE_AW-1:0] LAST_LINE = LINE_AW'(NUM_LINES - 1);

  state_t             r_state, w_state_next;
  logic               r_load_req, r_load_buf;
  logic [LINE_AW-1:0] r_load_line;
  logic               r_pend, r_pend_buf;
  logic [LINE_AW-1:0] r_pend_line;
  logic               r_rdy [2];
  logic               r_active_sl;
  logic [LINE_AW-1:0] r_cur_line;

  logic               w_ack, w_col_valid, w_last, w_line_end, w_final, w_wrap_ok;
  logic               w_next_buf, w_next_rdy, w_fill_en;
  logic [LINE_AW-1:0] w_next_line, w_fill_line;
  logic               w_start_load, w_adv, w_line_clr;
  logic               w_req, w_req_buf;
  logic [LINE_AW-1:0] w_req_line;

`ifdef KARAOKE_LOOP_EN
  assign w_wrap_ok = 1'b1;
`else
  assign w_wrap_ok = 1'b0;
`endif

  assign w_ack       = r_load_req && load_ack;
  assign w_col_valid = (r_state == ST_PLAY) && !pause;
  assign w_line_end  = w_col_valid && w_last;
  assign w_final     = (r_cur_line == LAST_LINE);
  assign w_next_line = w_final ? '0 : r_cur_line + LINE_AW'(1);
  assign w_fill_line = (w_next_line == LAST_LINE) ? '0 : w_next_line + LINE_AW'(1);
  assign w_fill_en   = w_wrap_ok || (!w_final && (w_next_line != LAST_LINE));
  // A one-line looping song reuses the same buffer, so it can never be pre-filled.
  assign w_next_buf  = (NUM_LINES == 1) ? r_active_sl : !r_active_sl;
  assign w_next_rdy  = (NUM_LINES > 1) &&
                       (r_rdy[w_next_buf] || (w_ack && (r_load_buf == w_next_buf)));

  always_comb begin
    w_state_next = r_state;
    w_start_load = 1'b0;
    w_adv        = 1'b0;
    w_line_clr   = 1'b0;
    w_req        = 1'b0;
    w_req_buf    = 1'b0;
    w_req_line   = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = ST_PRELOAD0;
          w_start_load = 1'b1;
          w_req        = 1'b1;
        end
      end
      ST_PRELOAD0: begin
        if (w_ack) begin
          if (NUM_LINES > 1) begin
            w_state_next = ST_PRELOAD1;
            w_req        = 1'b1;
            w_req_buf    = 1'b1;
            w_req_line   = LINE_AW'(1);
          end else begin
            w_state_next = ST_PLAY;
          end
        end
      end
      ST_PRELOAD1: begin
        if (w_ack) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_line_end) begin
          w_line_clr = 1'b1;
          if (w_final && !w_wrap_ok) begin
            w_state_next = ST_DONE;
          end else begin
            w_req      = w_fill_en;
            w_req_buf  = r_active_sl;
            w_req_line = w_fill_line;
            if (w_next_rdy) w_adv = 1'b1;
            else            w_state_next = ST_WAIT_LOAD;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (w_ack && (r_load_buf == w_next_buf)) begin
          w_adv        = 1'b1;
          w_state_next = ST_PLAY;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A request raised while another is outstanding (or just acked) waits in the
  // pending slot, so load_req always drops for a cycle between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_load_req  <= 1'b0;
      r_load_buf  <= 1'b0;
      r_load_line <= '0;
      r_pend      <= 1'b0;
      r_pend_buf  <= 1'b0;
      r_pend_line <= '0;
      r_active_sl <= 1'b0;
      r_cur_line  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_ack) r_load_req <= 1'b0;
      if (w_req) begin
        if (r_load_req) begin
          r_pend      <= 1'b1;
          r_pend_buf  <= w_req_buf;
          r_pend_line <= w_req_line;
        end else begin
          r_load_req  <= 1'b1;
          r_load_buf  <= w_req_buf;
          r_load_line <= w_req_line;
        end
      end else if (r_pend && !r_load_req) begin
        r_load_req  <= 1'b1;
        r_load_buf  <= r_pend_buf;
        r_load_line <= r_pend_line;
        r_pend      <= 1'b0;
      end
      if (w_start_load) begin
        r_active_sl <= 1'b0;
        r_cur_line  <= '0;
      end else if (w_adv) begin
        r_active_sl <= w_next_buf;
        r_cur_line  <= w_next_line;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rdy
    always_ff @(posedge clk) begin
      if (rst || w_start_load) begin
        r_rdy[gi] <= 1'b0;
      end else if (w_ack && (r_load_buf == 1'(gi))) begin
        r_rdy[gi] <= 1'b1;
      end else if (w_line_clr && (r_active_sl == 1'(gi))) begin
        r_rdy[gi] <= 1'b0;
      end
    end
  end

  karaoke_col_counter #(
    .CPSBLN (CPSBLN),
    .CHAR_W (CHAR_W)
  ) u_col_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start_load),
    .i_en       (w_col_valid),
    .o_char_idx (char_idx),
    .o_col_idx  (col_idx),
    .o_last     (w_last)
  );

  assign load_req  = r_load_req;
  assign load_buf  = r_load_buf;
  assign load_line = r_load_line;
  assign col_valid = w_col_valid;
  assign active_sl = r_active_sl;
  assign cur_line  = r_cur_line;
  assign line_done = w_line_end;
  assign song_done = (r_state == ST_DONE);

endmodule
